// File: rtl/io_uart_master.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// io_uart_master
//
// MMIO initiator for the IO controller's CPU-side port. It stands in for CPU
// loads/stores so that a hardware loader or console path can move bytes
// through the on-chip UART:
//   * a byte offered on tx_data/tx_valid is parked in a one-entry TX holding
//     register, then written to the UART TX data address once a status poll
//     reports the UART transmitter ready;
//   * when a status poll reports a received byte and the one-entry RX holding
//     register is free, the byte is read from the UART RX data address and
//     presented on rx_data/rx_valid.
//
// IO map (word addresses):
//   0x00 status  : bit0 = UART TX ready, bit1 = UART RX valid
//   0x01 RX data : bits [7:0]
//   0x02 TX data : din_io[7:0]
//
// Ports:
//   clk       in   clock
//   cpu_rst_n in   asynchronous active-low reset
//   tx_data   in   byte to transmit
//   tx_valid  in   tx_data valid
//   tx_ready  out  TX holding register empty
//   rx_data   out  received byte (held until the next fill)
//   rx_valid  out  RX holding register full
//   rx_ready  in   consumer accepts rx_data
//   io_en     out  IO access strobe, one cycle per access
//   wea       out  byte write enables, 0 = read
//   adr       out  IO word address
//   din_io    out  write data
//   dout_io   in   responder read data, valid the cycle after a read strobe
//   busy      out  FSM is not idle
// -----------------------------------------------------------------------------
module io_uart_master #(
  parameter int ADR_W    = 5,
  parameter int XLEN     = 32,
  parameter int POLL_GAP = 0
) (
  input  logic             clk,
  input  logic             cpu_rst_n,
  input  logic [7:0]       tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [7:0]       rx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic             io_en,
  output logic [3:0]       wea,
  output logic [ADR_W-1:0] adr,
  output logic [XLEN-1:0]  din_io,
  input  logic [XLEN-1:0]  dout_io,
  output logic             busy
);

  localparam logic [ADR_W-1:0] ADR_STATUS = ADR_W'(0);
  localparam logic [ADR_W-1:0] ADR_RX     = ADR_W'(1);
  localparam logic [ADR_W-1:0] ADR_TX     = ADR_W'(2);

  // GAP holds for POLL_GAP cycles: the counter is loaded with POLL_GAP-1 on
  // entry and GAP is left when it reaches zero.
  localparam int GAP_W = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = (POLL_GAP > 0) ? GAP_W'(POLL_GAP - 1) : '0;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_POLL      = 3'd1,
    S_POLL_WAIT = 3'd2,
    S_RD_RX     = 3'd3,
    S_RD_WAIT   = 3'd4,
    S_WR_TX     = 3'd5,
    S_GAP       = 3'd6
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [GAP_W-1:0] gap_cnt;

  logic             tx_full;
  logic [7:0]       tx_byte;
  logic             rx_full;
  logic [7:0]       rx_byte;

  // Only the low byte of read data is ever meaningful to this block.
  logic unused_dout_hi;
  assign unused_dout_hi = ^dout_io[XLEN-1:8];

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours; the async reset sits in the
  // sensitivity list so outputs decoded from state drop without a clock.
  always_ff @(posedge clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every always_comb output gets a default before the case so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        // Poll while there is room for a received byte or a byte to send.
        if (!rx_full || tx_full) state_nxt = S_POLL;
      end
      S_POLL: begin
        state_nxt = S_POLL_WAIT;
      end
      S_POLL_WAIT: begin
        // Receive has priority so the UART RX FIFO cannot back up behind a
        // stream of transmits. Flags are the registered ones: a same-cycle
        // tx accept or rx drain is seen on the next poll.
        if (dout_io[1] && !rx_full) begin
          state_nxt = S_RD_RX;
        end else if (dout_io[0] && tx_full) begin
          state_nxt = S_WR_TX;
        end else if (POLL_GAP > 0) begin
          state_nxt = S_GAP;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_RD_RX: begin
        state_nxt = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        state_nxt = S_IDLE;
      end
      S_WR_TX: begin
        state_nxt = S_IDLE;
      end
      S_GAP: begin
        if (gap_cnt == '0) state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Poll back-off counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      gap_cnt <= '0;
    end else if (state == S_POLL_WAIT && state_nxt == S_GAP) begin
      gap_cnt <= GAP_LOAD;
    end else if (state == S_GAP && gap_cnt != '0) begin
      gap_cnt <= gap_cnt - GAP_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // TX holding register
  // ---------------------------------------------------------------------------
  // The write strobe in WR_TX is the only consumer, so the register frees at
  // the end of that cycle and tx_ready rises on the one after.
  always_ff @(posedge clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      tx_full <= 1'b0;
      tx_byte <= 8'h00;
    end else if (state == S_WR_TX) begin
      tx_full <= 1'b0;
    end else if (tx_valid && !tx_full) begin
      tx_full <= 1'b1;
      tx_byte <= tx_data;
    end
  end

  assign tx_ready = !tx_full;

  // ---------------------------------------------------------------------------
  // RX holding register
  // ---------------------------------------------------------------------------
  // RD_RX is only entered with the register empty, so a fill can never
  // collide with a consumer handshake. rx_byte keeps its value after a drain.
  always_ff @(posedge clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      rx_full <= 1'b0;
      rx_byte <= 8'h00;
    end else if (state == S_RD_WAIT) begin
      rx_full <= 1'b1;
      rx_byte <= dout_io[7:0];
    end else if (rx_full && rx_ready) begin
      rx_full <= 1'b0;
    end
  end

  assign rx_valid = rx_full;
  assign rx_data  = rx_byte;

  // ---------------------------------------------------------------------------
  // Bus outputs: Moore decode of the state register
  // ---------------------------------------------------------------------------
  always_comb begin
    io_en  = 1'b0;
    wea    = 4'b0000;
    adr    = ADR_STATUS;
    din_io = '0;
    unique case (state)
      S_POLL: begin
        io_en = 1'b1;
        adr   = ADR_STATUS;
      end
      S_RD_RX: begin
        io_en = 1'b1;
        adr   = ADR_RX;
      end
      S_WR_TX: begin
        io_en  = 1'b1;
        wea    = 4'b0001;
        adr    = ADR_TX;
        din_io = {{(XLEN-8){1'b0}}, tx_byte};
      end
      default: begin
      end
    endcase
  end

  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_io_uart_master.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_io_uart_master
//
// Drives io_uart_master against a behavioural UART responder. The responder
// answers status polls from a bench-controlled status word, answers RX data
// reads with bytes it records in an expected-RX queue, and returns random
// junk everywhere else. Bytes handed to tx_data are recorded in an
// expected-TX queue; every write on the bus must match its head, and every
// byte leaving on rx_data must match the head of the expected-RX queue.
// A second instance with POLL_GAP=3 idles with status 0 to measure back-off.
// -----------------------------------------------------------------------------
module tb_io_uart_master;

  localparam int ADR_W = 5;
  localparam int XLEN  = 32;

  logic             clk = 1'b0;
  logic             cpu_rst_n;
  logic [7:0]       tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic [7:0]       rx_data;
  logic             rx_valid;
  logic             rx_ready;
  logic             io_en;
  logic [3:0]       wea;
  logic [ADR_W-1:0] adr;
  logic [XLEN-1:0]  din_io;
  logic [XLEN-1:0]  dout_io;
  logic             busy;

  logic             g_tx_ready;
  logic [7:0]       g_rx_data;
  logic             g_rx_valid;
  logic             g_io_en;
  logic [3:0]       g_wea;
  logic [ADR_W-1:0] g_adr;
  logic [XLEN-1:0]  g_din_io;
  logic [XLEN-1:0]  g_dout_io;
  logic             g_busy;

  int checks   = 0;
  int failures = 0;

  logic [1:0]  status;       // UART status the responder reports
  logic [1:0]  last_status;  // status returned by the most recent poll
  logic [7:0]  exp_tx[$];    // accepted bytes not yet written to the UART
  logic [7:0]  exp_rx[$];    // bytes read from the UART not yet delivered
  logic [7:0]  rx_src[$];    // directed RX bytes for the responder to return
  logic [31:0] junk;
  logic [31:0] g_junk;
  logic [7:0]  resp_byte;

  always #5 clk = ~clk;

  io_uart_master #(.ADR_W(ADR_W), .XLEN(XLEN), .POLL_GAP(0)) u_dut (
    .clk      (clk),
    .cpu_rst_n(cpu_rst_n),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .io_en    (io_en),
    .wea      (wea),
    .adr      (adr),
    .din_io   (din_io),
    .dout_io  (dout_io),
    .busy     (busy)
  );

  io_uart_master #(.ADR_W(ADR_W), .XLEN(XLEN), .POLL_GAP(3)) u_dut_gap (
    .clk      (clk),
    .cpu_rst_n(cpu_rst_n),
    .tx_data  (8'h00),
    .tx_valid (1'b0),
    .tx_ready (g_tx_ready),
    .rx_data  (g_rx_data),
    .rx_valid (g_rx_valid),
    .rx_ready (1'b0),
    .io_en    (g_io_en),
    .wea      (g_wea),
    .adr      (g_adr),
    .din_io   (g_din_io),
    .dout_io  (g_dout_io),
    .busy     (g_busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    check(tag, 64'(obs), 64'(exp));
  endtask

  // ---------------------------------------------------------------------------
  // UART responder: registered read data, one cycle after the strobe.
  // ---------------------------------------------------------------------------
  always @(posedge clk) begin
    junk   = $urandom;
    g_junk = $urandom;
    g_dout_io <= {g_junk[31:2], 2'b00};
    if (io_en && wea == 4'b0000 && adr == ADR_W'(0)) begin
      dout_io     <= {junk[31:2], status};
      last_status <= status;
    end else if (io_en && wea == 4'b0000 && adr == ADR_W'(1)) begin
      if (rx_src.size() != 0) resp_byte = rx_src.pop_front();
      else                    resp_byte = junk[7:0];
      dout_io <= {junk[31:8], resp_byte};
      exp_rx.push_back(resp_byte);
    end else begin
      dout_io <= junk;
    end
  end

  // ---------------------------------------------------------------------------
  // Bus and stream monitor, sampled mid-cycle.
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    if (cpu_rst_n) begin
      if (tx_valid && tx_ready) exp_tx.push_back(tx_data);
      if (rx_valid && rx_ready) begin
        check1("rx_hs_expected", exp_rx.size() != 0, 1'b1);
        if (exp_rx.size() != 0) check("rx_hs_data", 64'(rx_data), 64'(exp_rx.pop_front()));
      end
      if (io_en) begin
        check1("acc_adr_legal", adr <= ADR_W'(2), 1'b1);
        if (adr == ADR_W'(2)) begin
          check("wr_wea", 64'(wea), 64'(4'b0001));
          check1("wr_permitted", last_status[0], 1'b1);
          check1("wr_expected", exp_tx.size() != 0, 1'b1);
          if (exp_tx.size() != 0) check("wr_data", 64'(din_io), 64'({24'h0, exp_tx.pop_front()}));
        end else begin
          check("rd_wea", 64'(wea), 64'(0));
          if (adr == ADR_W'(1)) begin
            check1("rd_permitted", last_status[1], 1'b1);
            check("rd_holding_empty", 64'(exp_rx.size()), 64'(0));
          end
        end
      end else begin
        check("idle_bus", 64'({wea, din_io}), 64'(0));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 20) begin
      tick();
      n++;
    end
    check1({tag, "_idle_reached"}, busy, 1'b0);
  endtask

  task automatic wait_acc(input string tag, input logic [ADR_W-1:0] a, input int budget);
    int n = 0;
    while (!(io_en && adr == a) && n < budget) begin
      tick();
      n++;
    end
    check1({tag, "_seen"}, io_en && adr == a, 1'b1);
  endtask

  task automatic push_tx(input logic [7:0] b);
    int n = 0;
    while (!tx_ready && n < 20) begin
      tick();
      n++;
    end
    check1("push_tx_ready", tx_ready, 1'b1);
    tx_data  = b;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Directed and random sequence
  // ---------------------------------------------------------------------------
  initial begin
    int q0[$];
    int q1[$];
    int reads;
    int writes;
    int n;

    cpu_rst_n = 1'b0;
    tx_valid  = 1'b0;
    tx_data   = 8'h00;
    rx_ready  = 1'b0;
    status    = 2'b00;
    repeat (3) tick();

    // Reset state
    check1("rst_tx_ready", tx_ready, 1'b1);
    check1("rst_rx_valid", rx_valid, 1'b0);
    check("rst_rx_data", 64'(rx_data), 64'(0));
    check1("rst_io_en", io_en, 1'b0);
    check("rst_wea", 64'(wea), 64'(0));
    check("rst_adr", 64'(adr), 64'(0));
    check("rst_din_io", 64'(din_io), 64'(0));
    check1("rst_busy", busy, 1'b0);
    check1("rst_gap_busy", g_busy, 1'b0);

    // Idle polling cadence: POLL, POLL_WAIT, IDLE without a gap; three more
    // GAP cycles in the back-off instance.
    cpu_rst_n = 1'b1;
    for (int i = 0; i < 24; i++) begin
      tick();
      if (io_en) begin
        q0.push_back(i);
        check("poll_adr", 64'(adr), 64'(0));
      end
      if (g_io_en) begin
        q1.push_back(i);
        check("gap_poll_adr", 64'(g_adr), 64'(0));
        check("gap_poll_wea", 64'(g_wea), 64'(0));
        check1("gap_poll_busy", g_busy, 1'b1);
      end
    end
    check1("poll_count", q0.size() >= 3, 1'b1);
    if (q0.size() >= 3) begin
      check("poll_first", 64'(q0[0]), 64'(0));
      check("poll_period_a", 64'(q0[1] - q0[0]), 64'(3));
      check("poll_period_b", 64'(q0[2] - q0[1]), 64'(3));
    end
    check1("gap_poll_count", q1.size() >= 3, 1'b1);
    if (q1.size() >= 3) begin
      check("gap_period_a", 64'(q1[1] - q1[0]), 64'(6));
      check("gap_period_b", 64'(q1[2] - q1[1]), 64'(6));
    end
    check1("idle_tx_ready", tx_ready, 1'b1);
    check1("idle_rx_valid", rx_valid, 1'b0);
    check1("gap_tx_ready", g_tx_ready, 1'b1);
    check1("gap_rx_valid", g_rx_valid, 1'b0);
    check("gap_rx_data", 64'(g_rx_data), 64'(0));
    check("gap_din_io", 64'(g_din_io), 64'(0));

    // TX latency: accepted in IDLE, write strobe three cycles later.
    status = 2'b01;
    wait_idle("tx_lat");
    tx_data  = 8'h5A;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    check1("tx_lat_ready_low", tx_ready, 1'b0);
    check1("tx_lat_c1_poll", io_en && adr == ADR_W'(0), 1'b1);
    tick();
    check1("tx_lat_c2_wait", io_en, 1'b0);
    tick();
    check1("tx_lat_c3_io_en", io_en, 1'b1);
    check("tx_lat_c3_adr", 64'(adr), 64'(2));
    check("tx_lat_c3_wea", 64'(wea), 64'(4'b0001));
    check("tx_lat_c3_din", 64'(din_io), 64'(32'h0000_005A));
    tick();
    check1("tx_lat_ready_back", tx_ready, 1'b1);
    check1("tx_lat_idle", busy, 1'b0);

    // RX priority over TX when both are possible.
    status = 2'b00;
    push_tx(8'h3C);
    rx_src.push_back(8'hA5);
    repeat (4) tick();
    check1("prio_tx_held", tx_ready, 1'b0);
    status = 2'b11;
    n = 0;
    while (!(io_en && adr != ADR_W'(0)) && n < 12) begin
      tick();
      n++;
    end
    check1("prio_first_seen", io_en && adr != ADR_W'(0), 1'b1);
    check("prio_first_is_read", 64'(adr), 64'(1));
    tick();
    check1("prio_rd_wait_valid", rx_valid, 1'b0);
    tick();
    check1("prio_rx_valid", rx_valid, 1'b1);
    check("prio_rx_data", 64'(rx_data), 64'(8'hA5));
    wait_acc("prio_write", ADR_W'(2), 12);
    check("prio_write_din", 64'(din_io), 64'(32'h0000_003C));

    // RX holding full: no read even with UART data waiting.
    status = 2'b10;
    reads  = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (io_en && adr == ADR_W'(1)) reads++;
    end
    check("full_no_reads", 64'(reads), 64'(0));
    check1("full_rx_valid", rx_valid, 1'b1);
    check("full_rx_data", 64'(rx_data), 64'(8'hA5));
    rx_src.push_back(8'h77);
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    check1("drain_rx_valid", rx_valid, 1'b0);
    check("drain_rx_data_held", 64'(rx_data), 64'(8'hA5));
    wait_acc("drain_read", ADR_W'(1), 8);
    tick();
    tick();
    check1("refill_rx_valid", rx_valid, 1'b1);
    check("refill_rx_data", 64'(rx_data), 64'(8'h77));
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;

    // Random traffic; the monitor checks every access and handshake.
    for (int c = 0; c < 3000; c++) begin
      status   = 2'($urandom);
      rx_ready = ($urandom_range(0, 3) != 0);
      tx_valid = ($urandom_range(0, 2) == 0);
      tx_data  = 8'($urandom);
      tick();
    end
    tx_valid = 1'b0;
    status   = 2'b01;
    rx_ready = 1'b1;
    n = 0;
    while ((exp_tx.size() != 0 || exp_rx.size() != 0 || rx_valid) && n < 60) begin
      tick();
      n++;
    end
    check("rand_tx_drained", 64'(exp_tx.size()), 64'(0));
    check("rand_rx_drained", 64'(exp_rx.size()), 64'(0));

    // Reset in the middle of WR_TX abandons the byte.
    rx_ready = 1'b0;
    status   = 2'b01;
    wait_idle("rst_wr");
    tx_data  = 8'h99;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    wait_acc("rst_wr", ADR_W'(2), 8);
    #2;
    cpu_rst_n = 1'b0;
    #1;
    check1("rst_wr_io_en", io_en, 1'b0);
    check("rst_wr_wea", 64'(wea), 64'(0));
    check("rst_wr_din", 64'(din_io), 64'(0));
    check1("rst_wr_tx_ready", tx_ready, 1'b1);
    check1("rst_wr_busy", busy, 1'b0);
    exp_tx.delete();
    exp_rx.delete();
    rx_src.delete();
    @(posedge clk);
    #1;
    cpu_rst_n = 1'b1;
    writes = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (io_en && adr == ADR_W'(2)) writes++;
    end
    check("rst_wr_no_resend", 64'(writes), 64'(0));
    check1("rst_wr_ready_after", tx_ready, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
